// File: rtl/gcbp_line_reader.sv
// gcbp_line_reader
//
// Purpose:
//   Reads the GCBP lines of one sub-image back out of the sub-image BRAM
//   that the GCBP line generator fills, one BRAM word per line, and streams
//   them in ascending line order over a valid/ready handshake. BRAM reads are
//   pipelined behind a 2-entry output FIFO. With the consumer always ready,
//   the block delivers one line per cycle.
//
// Ports:
//   i_clk           clock
//   i_reset         asynchronous, active-high reset
//   i_start         single-cycle request to begin a read pass
//   i_subimage_sel  sub-image to read, sampled when i_start is accepted
//   o_busy          high from the accepted start until o_done
//   o_bram_addr     BRAM read address {subimage, line}
//   o_bram_en       BRAM read enable
//   i_bram_data     BRAM read data, valid one cycle after o_bram_en
//   o_line          line data (FIFO head)
//   o_line_idx      line number of o_line
//   o_line_last     o_line is the last line of the sub-image
//   o_line_valid    o_line / o_line_idx / o_line_last are valid
//   i_line_ready    consumer accepts; a transfer happens on valid && ready
//   o_done          one-cycle pulse when the pass completes
//
// Configuration macro:
//   GCBP_LINE_READER_BITREV_EN  when defined, every word is bit-reversed as it
//                               enters the FIFO, so the leftmost pixel of the
//                               sub-image lands on bit 0 of o_line.

module gcbp_line_reader #(
    parameter int  BRAM_DATA_WIDTH = 128,
    parameter int  NUM_LINES       = 128,
    parameter int  NUM_SUBIMAGES   = 4,
    localparam int C_LINE_BITS     = $clog2(NUM_LINES),
    localparam int C_SUB_BITS      = $clog2(NUM_SUBIMAGES)
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_start,
    input  logic [C_SUB_BITS-1:0]             i_subimage_sel,
    output logic                              o_busy,
    output logic [C_SUB_BITS+C_LINE_BITS-1:0] o_bram_addr,
    output logic                              o_bram_en,
    input  logic [BRAM_DATA_WIDTH-1:0]        i_bram_data,
    output logic [BRAM_DATA_WIDTH-1:0]        o_line,
    output logic [C_LINE_BITS-1:0]            o_line_idx,
    output logic                              o_line_last,
    output logic                              o_line_valid,
    input  logic                              i_line_ready,
    output logic                              o_done
);

    localparam int ADDR_BITS = C_SUB_BITS + C_LINE_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [C_SUB_BITS-1:0]       sub_q, sub_d;
    logic [C_LINE_BITS:0]        issue_cnt_q, issue_cnt_d;
    logic                        inflight_q, inflight_d;
    logic [C_LINE_BITS-1:0]      inflight_idx_q, inflight_idx_d;
    logic [ADDR_BITS-1:0]        last_addr_q, last_addr_d;

    logic [BRAM_DATA_WIDTH-1:0]  fifo_data_q [2];
    logic [BRAM_DATA_WIDTH-1:0]  fifo_data_d [2];
    logic [C_LINE_BITS-1:0]      fifo_idx_q  [2];
    logic [C_LINE_BITS-1:0]      fifo_idx_d  [2];
    logic [1:0]                  fifo_last_q, fifo_last_d;
    logic                        wr_ptr_q, wr_ptr_d;
    logic                        rd_ptr_q, rd_ptr_d;
    logic [1:0]                  count_q, count_d;

    logic                        pop;
    logic                        issue;
    logic [1:0]                  outstanding;
    logic [C_LINE_BITS-1:0]      issue_line;
    logic [BRAM_DATA_WIDTH-1:0]  push_word;

    // The word entering the FIFO is optionally bit-reversed here so the
    // reversal costs no extra pipeline stage.
`ifdef GCBP_LINE_READER_BITREV_EN
    always_comb begin
        push_word = '0;
        for (int i = 0; i < BRAM_DATA_WIDTH; i++) begin
            push_word[i] = i_bram_data[BRAM_DATA_WIDTH-1-i];
        end
    end
`else
    assign push_word = i_bram_data;
`endif

    // Occupancy plus the read in flight, after this cycle's transfer frees
    // its slot. Keeping this below 2 before issuing means the returning word
    // always has a free FIFO entry.
    assign pop         = (count_q != 2'd0) && i_line_ready;
    assign outstanding = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue_line  = issue_cnt_q[C_LINE_BITS-1:0];

    // The extra MSB of the issue counter marks "all lines issued" without
    // relying on the line index wrapping.
    assign issue = (state_q == S_READ) && !issue_cnt_q[C_LINE_BITS]
                   && (outstanding < 2'd2);

    // Control FSM and read issue.
    always_comb begin
        state_d        = state_q;
        sub_d          = sub_q;
        issue_cnt_d    = issue_cnt_q;
        inflight_d     = 1'b0;
        inflight_idx_d = inflight_idx_q;
        last_addr_d    = last_addr_q;
        o_done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    sub_d       = i_subimage_sel;
                    issue_cnt_d = '0;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                if (issue && (issue_line == {C_LINE_BITS{1'b1}})) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    o_done  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            issue_cnt_d    = issue_cnt_q + {{C_LINE_BITS{1'b0}}, 1'b1};
            inflight_d     = 1'b1;
            inflight_idx_d = issue_line;
            last_addr_d    = {sub_q, issue_line};
        end
    end

    // Two-entry FIFO: the word returning from BRAM is pushed together with
    // its line index and last flag; the head drives the outputs.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_idx_d  = fifo_idx_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = outstanding;

        if (inflight_q) begin
            fifo_data_d[wr_ptr_q] = push_word;
            fifo_idx_d[wr_ptr_q]  = inflight_idx_q;
            fifo_last_d[wr_ptr_q] = (inflight_idx_q == {C_LINE_BITS{1'b1}});
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // Reset abandons any pass: clearing inflight_q drops the word still
    // coming back from BRAM.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= S_IDLE;
            sub_q          <= '0;
            issue_cnt_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            last_addr_q    <= '0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_idx_q[0]  <= '0;
            fifo_idx_q[1]  <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            sub_q          <= sub_d;
            issue_cnt_q    <= issue_cnt_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            last_addr_q    <= last_addr_d;
            fifo_data_q    <= fifo_data_d;
            fifo_idx_q     <= fifo_idx_d;
            fifo_last_q    <= fifo_last_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // The address holds the last issued value whenever no read is issued.
    assign o_busy       = (state_q != S_IDLE);
    assign o_bram_en    = issue;
    assign o_bram_addr  = issue ? {sub_q, issue_line} : last_addr_q;
    assign o_line_valid = (count_q != 2'd0);
    assign o_line       = fifo_data_q[rd_ptr_q];
    assign o_line_idx   = fifo_idx_q[rd_ptr_q];
    assign o_line_last  = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_gcbp_line_reader.sv
// tb_gcbp_line_reader
//
// Purpose:
//   Directed self-checking bench for gcbp_line_reader. A registered BRAM
//   model returns the read address zero-extended to 128 bits, so every line's
//   expected content follows from its sub-image and line number.
//
// Configuration macro:
//   GCBP_LINE_READER_BITREV_EN  expected line data is bit-reversed when set.

module tb_gcbp_line_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   sel;
    logic         busy;
    logic [8:0]   addr;
    logic         en;
    logic [127:0] bram_q;
    logic [127:0] line;
    logic [6:0]   idx;
    logic         last;
    logic         valid;
    logic         ready;
    logic         done;

    int           vectors = 0;
    int           errors  = 0;
    int           nb, fv, dc;
    logic [127:0] beat1_line;
    logic [127:0] word_one_exp;

    gcbp_line_reader dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_subimage_sel (sel),
        .o_busy         (busy),
        .o_bram_addr    (addr),
        .o_bram_en      (en),
        .i_bram_data    (bram_q),
        .o_line         (line),
        .o_line_idx     (idx),
        .o_line_last    (last),
        .o_line_valid   (valid),
        .i_line_ready   (ready),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    // Registered BRAM: stored word equals its own address.
    always @(posedge clk) begin
        if (en) bram_q <= {119'd0, addr};
    end

    function automatic logic [127:0] exp_line(input logic [1:0] s, input logic [6:0] i);
        logic [127:0] w;
        logic [127:0] r;
        w      = '0;
        w[8:0] = {s, i};
`ifdef GCBP_LINE_READER_BITREV_EN
        r = '0;
        for (int b = 0; b < 128; b++) r[b] = w[127-b];
`else
        r = w;
`endif
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string phase);
        check_output({phase, "_busy"},  128'(busy),  128'(0));
        check_output({phase, "_en"},    128'(en),    128'(0));
        check_output({phase, "_addr"},  128'(addr),  128'(0));
        check_output({phase, "_valid"}, 128'(valid), 128'(0));
        check_output({phase, "_line"},  line,        128'(0));
        check_output({phase, "_idx"},   128'(idx),   128'(0));
        check_output({phase, "_last"},  128'(last),  128'(0));
        check_output({phase, "_done"},  128'(done),  128'(0));
    endtask

    // One read pass. mode 0: always ready, 1: random ready, 2: stalled for
    // the first 20 cycles. restart_at pulses i_start (sel 3) when that many
    // beats have been taken; reset_at asserts reset at that beat count.
    // Cycle c=0 is the first cycle after the accepted start.
    task automatic apply_stimulus(input logic [1:0] s, input int mode, input int restart_at,
                                  input int reset_at, output int beats,
                                  output int first_valid_c, output int done_c);
        int           outstanding;
        int           issued;
        int           last_xfer_c;
        bit           restarted;
        logic         pop;
        logic         p_valid;
        logic         p_ready;
        logic [127:0] p_line;
        logic [6:0]   p_idx;
        logic         p_last;

        beats = 0; first_valid_c = -1; done_c = -1;
        outstanding = 0; issued = 0; last_xfer_c = -1; restarted = 0;
        p_valid = 1'b0; p_ready = 1'b1; p_line = '0; p_idx = '0; p_last = 1'b0;

        @(negedge clk);
        start = 1'b1;
        sel   = s;
        @(negedge clk);
        start = 1'b0;
        sel   = ~s;

        for (int c = 0; c < 2000; c++) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = (c >= 20);
            endcase
            if (restart_at >= 0 && beats == restart_at && !restarted) begin
                start     = 1'b1;
                sel       = 2'd3;
                restarted = 1;
            end else begin
                start = 1'b0;
            end
            if (reset_at >= 0 && beats == reset_at) begin
                rst   = 1'b1;
                ready = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                @(negedge clk);
                @(negedge clk);
                #1;
                check_reset_outputs("mid_reset_hold");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            #1;
            pop = valid && ready;
            if (c == 0) check_output("busy_after_start", 128'(busy), 128'(1));
            if (valid && first_valid_c < 0) first_valid_c = c;
            if (mode == 2 && c == 19) begin
                check_output("stall_issued",   128'(issued), 128'(2));
                check_output("stall_valid",    128'(valid),  128'(1));
                check_output("stall_idx",      128'(idx),    128'(0));
            end
            if (en) begin
                check_output("issue_limit", 128'((outstanding - int'(pop)) < 2), 128'(1));
                check_output("issue_addr",  128'(addr), 128'({s, issued[6:0]}));
                issued++;
            end
            if (p_valid && !p_ready) begin
                check_output("hold_valid", 128'(valid), 128'(1));
                check_output("hold_line",  line,        p_line);
                check_output("hold_idx",   128'(idx),   128'(p_idx));
                check_output("hold_last",  128'(last),  128'(p_last));
            end
            if (pop) begin
                check_output("beat_idx",  128'(idx),  128'(beats[6:0]));
                check_output("beat_line", line,       exp_line(s, beats[6:0]));
                check_output("beat_last", 128'(last), 128'(beats == 127));
                if (beats == 1) beat1_line = line;
                beats++;
                last_xfer_c = c;
            end
            if (done) begin
                check_output("done_after_last", 128'(c - last_xfer_c), 128'(1));
                check_output("done_beats",      128'(beats),           128'(128));
                done_c = c;
                break;
            end
            outstanding = outstanding + int'(en) - int'(pop);
            p_valid = valid; p_ready = ready; p_line = line; p_idx = idx; p_last = last;
            @(negedge clk);
        end

        if (done_c < 0) begin
            check_output("done_timeout", 128'(beats), 128'(128));
        end else begin
            @(negedge clk);
            #1;
            check_output("busy_after_done", 128'(busy), 128'(0));
            check_output("done_one_cycle",  128'(done), 128'(0));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 2'd0; ready = 1'b0;
        beat1_line = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("[TB] reset state");
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] full-rate pass on sub-image 2");
        apply_stimulus(2'd2, 0, -1, -1, nb, fv, dc);
        check_output("t1_first_valid_c",     128'(fv),     128'(2));
        check_output("t1_start_to_done",     128'(dc + 1), 128'(131));

        $display("[TB] random ready on sub-image 0");
        apply_stimulus(2'd0, 1, -1, -1, nb, fv, dc);
        check_output("t2_beats", 128'(nb), 128'(128));
`ifdef GCBP_LINE_READER_BITREV_EN
        word_one_exp = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
`else
        word_one_exp = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
`endif
        check_output("t6_word_one", beat1_line, word_one_exp);

        $display("[TB] initial 20-cycle stall on sub-image 1");
        apply_stimulus(2'd1, 2, -1, -1, nb, fv, dc);
        check_output("t3_beats", 128'(nb), 128'(128));

        $display("[TB] start while busy is ignored");
        apply_stimulus(2'd0, 0, 50, -1, nb, fv, dc);
        check_output("t4_beats", 128'(nb), 128'(128));
        apply_stimulus(2'd3, 0, -1, -1, nb, fv, dc);
        check_output("t4_sel3_beats", 128'(nb), 128'(128));

        $display("[TB] reset mid-pass then fresh pass");
        apply_stimulus(2'd0, 0, -1, 70, nb, fv, dc);
        apply_stimulus(2'd1, 0, -1, -1, nb, fv, dc);
        check_output("t5_beats",      128'(nb), 128'(128));
        check_output("t5_first_valid", 128'(fv), 128'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gcbp_line_reader.md
Name: gcbp_line_reader

Overview:
Reads stored GCBP lines back out of the sub-image BRAM that the GCBP line generator fills, one 128-bit word per line. It streams the lines to the downstream matching logic through a valid/ready handshake.
Each read pass covers one selected sub-image, lines 0..NUM_LINES-1 in order. BRAM reads are pipelined behind a 2-entry output buffer, so throughput is one line per cycle when the consumer is always ready.

Parameters:
BRAM_DATA_WIDTH, 128, width of one GCBP line / BRAM word
NUM_LINES, 128, lines per sub-image (power of 2)
NUM_SUBIMAGES, 4, horizontal sub-images (power of 2)
C_LINE_BITS (local), log2(NUM_LINES) = 7
C_SUB_BITS (local), log2(NUM_SUBIMAGES) = 2

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_start  in  1  single-cycle request to begin a read pass
i_subimage_sel  in  C_SUB_BITS  sub-image to read; sampled when i_start is accepted
o_busy  out  1  high from accepted start until o_done
o_bram_addr  out  C_SUB_BITS+C_LINE_BITS  {subimage, line}
o_bram_en  out  1  BRAM read enable
i_bram_data  in  BRAM_DATA_WIDTH  read data, valid exactly 1 cycle after o_bram_en
o_line  out  BRAM_DATA_WIDTH  line data
o_line_idx  out  C_LINE_BITS  line number of o_line
o_line_last  out  1  o_line is line NUM_LINES-1
o_line_valid  out  1  o_line/o_line_idx/o_line_last valid
i_line_ready  in  1  consumer accepts; a transfer happens when valid && ready
o_done  out  1  1-cycle pulse when the pass completes

Behaviour:
- Reset (async, i_reset=1): all outputs are 0; FSM = S_IDLE; buffer empty; counters 0. Reset mid-pass abandons the pass immediately, and any in-flight BRAM data is discarded.
- FSM states:
  - S_IDLE: i_start=1 latches i_subimage_sel, clears the issue and line counters, and goes to S_READ. o_busy rises the next cycle.
  - S_READ: issues reads. After the read of line NUM_LINES-1 is issued, goes to S_DRAIN.
  - S_DRAIN: waits until the buffer is empty and nothing is in flight. Then asserts o_done for 1 cycle and returns to S_IDLE.
- i_start while o_busy=1 is ignored; no queuing.
- Read issue rule: o_bram_en=1 in S_READ only when (buffer occupancy + reads in flight) < 2, counting a transfer in the same cycle as freeing a slot. This guarantees the buffer never overflows.
- When issuing, o_bram_addr = {latched subimage, issue counter}, and the issue counter increments. o_bram_addr holds its value when o_bram_en=0.
- BRAM latency is 1 cycle. The returning word is written into the 2-entry FIFO together with its line index and a last flag.
- Outputs are driven from the FIFO head. o_line_valid = FIFO not empty. While valid && !ready, o_line, o_line_idx and o_line_last hold stable.
- Throughput: with i_line_ready held at 1, one line per cycle.
  - First o_line_valid appears 2 cycles after the accepted i_start (1 cycle state change + 1 cycle BRAM latency).
  - o_done occurs 1 cycle after the last transfer.
- Ordering: lines always come out in strictly ascending order 0..NUM_LINES-1; no gaps or duplicates.
- Counter widths: the issue counter is C_LINE_BITS+1 bits so that "all issued" is detected without wrap. Line indices wrap naturally and are never compared modulo.
- Simultaneous events: FIFO push and pop in the same cycle keep the occupancy unchanged. With occupancy 2 and a pop in that cycle, a new read may be issued.

Optional Feature:
GCBP_LINE_READER_BITREV_EN:
- Defined: o_line is the bit-reverse of the stored word (o_line[i] = word[BRAM_DATA_WIDTH-1-i]). Because the generator shifts pixels in at the LSB, this puts the leftmost pixel of the sub-image at bit 0.
- Undefined: o_line = stored word unchanged.
- The reversal is applied at the FIFO write, so it adds no cycles of latency.

Test Plan:
1. BRAM preloaded with word = {subimage, line} pattern; i_start with sel=2, i_line_ready=1 -> 128 beats, idx 0..127, data matches addresses 256..383, o_line_last on idx 127 only, o_done 1 cycle after the last beat; total 131 cycles from start to done.
2. Random i_line_ready (50%) on sel=0 -> no loss or duplication; data holds while stalled; o_bram_en is never asserted when occupancy+inflight=2.
3. i_line_ready=0 for 20 cycles after start -> exactly 2 reads issued, o_line_valid held on idx 0; after release, the stream completes normally.
4. i_start pulsed again at beat 50 with sel=3 -> ignored; the pass continues on sel=0; a subsequent start after o_done reads sel=3 (addresses 384..511).
5. i_reset asserted at beat 70, released, then start sel=1 -> outputs 0 during reset; the new pass starts at idx 0 with no stale data from the aborted pass.
6. With GCBP_LINE_READER_BITREV_EN defined, stored word 0x1 -> o_line = 0x8000...0000 (bit 127 set); without the macro -> 0x1.
